picobello_mesh_edge_responder: RTL
==================================

Name: picobello_mesh_edge_responder

Overview:
- Terminates one tied-off mesh port on an edge tile (x==0/West, x==NumXMesh-1/East, y==0/South, y==NumYMesh-1/North).
- Any request that is misrouted off the mesh edge is fully consumed, and the block answers it with a DECERR response routed back to the originating tile.
- The initiator therefore never hangs.
- One instance sits per tied-off port on the narrow request/response link. Status is visible to the tile's register file.

Parameters:
- TileX, 0, X coordinate of the hosting tile; used as response source.
- TileY, 0, Y coordinate of the hosting tile; used as response source.
- CoordW, 2, width of an X or Y coordinate; must hold NumXMesh-1 and NumYMesh-1.
- IdW, 4, transaction ID width.
- LenW, 8, burst length width (AXI len, beats-1).
- CntW, 16, width of the error/stray counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  request flit valid
- req_ready_o  out  1  request flit ready
- req_hdr_i  in  1  flit is a header (AW/AR); 0 = write data flit
- req_write_i  in  1  header is AW (1) or AR (0)
- req_src_x_i  in  CoordW  header source X
- req_src_y_i  in  CoordW  header source Y
- req_id_i  in  IdW  header transaction ID
- req_len_i  in  LenW  header burst length (beats-1)
- req_last_i  in  1  data flit is last W beat
- rsp_valid_o  out  1  response flit valid
- rsp_ready_i  in  1  response flit ready
- rsp_dst_x_o  out  CoordW  response destination X (= latched source X)
- rsp_dst_y_o  out  CoordW  response destination Y (= latched source Y)
- rsp_src_x_o  out  CoordW  constant TileX
- rsp_src_y_o  out  CoordW  constant TileY
- rsp_id_o  out  IdW  latched ID
- rsp_write_o  out  1  1 = B response, 0 = R beat
- rsp_last_o  out  1  last response beat
- rsp_resp_o  out  2  response code, always 2'b11 (DECERR)
- clr_i  in  1  clears sticky status and counters
- err_o  out  1  sticky: at least one header terminated
- err_cnt_o  out  CntW  saturating count of terminated headers
- stray_cnt_o  out  CntW  saturating count of data flits received in IDLE

Behaviour:
- Clock and reset:
  - Single clock clk_i; reset is synchronous and active-low (rst_ni).
  - Reset, including mid-burst: FSM goes to IDLE; every register clears.
  - Out of reset: rsp_valid_o=0, rsp_dst/id/write/last=0, err_o=0, counters=0, req_ready_o=1.
  - Partially drained bursts are abandoned.
- FSM states: IDLE, W_DRAIN, R_RESP, B_RESP. Only one transaction is in flight; further headers are back-pressured.
- IDLE:
  - req_ready_o=1, rsp_valid_o=0.
  - Header handshake latches src_x, src_y, id and len.
  - Write header -> W_DRAIN. Read header -> R_RESP with beat counter = len.
  - Data flit handshake in IDLE -> flit dropped, stray_cnt_o += 1, stay in IDLE.
- W_DRAIN:
  - req_ready_o = !req_hdr_i, so a new header stalls.
  - Every data flit is accepted and discarded. Flit with req_last_i=1 -> B_RESP.
  - Beat count is not checked against len; termination is on last only.
- B_RESP:
  - req_ready_o=0, rsp_valid_o=1, rsp_write_o=1, rsp_last_o=1.
  - Handshake -> IDLE.
- R_RESP:
  - req_ready_o=0, rsp_valid_o=1, rsp_write_o=0, rsp_last_o = (cnt==0).
  - On handshake: if cnt==0 -> IDLE, else cnt -= 1.
  - len=255 yields exactly 256 beats; no wrap.
- Latency and stability:
  - First response flit is valid the cycle after header acceptance.
  - Consecutive R beats are issued back-to-back when rsp_ready_i=1.
  - All rsp_* outputs are registered.
  - Once rsp_valid_o=1, it and all rsp fields hold stable until rsp_ready_i=1. Valid never depends on ready.
- Status and counters:
  - err_cnt_o increments and err_o sets on every header handshake.
  - Both counters saturate at 2^CntW-1.
- clr_i:
  - Clears err_o and both counters.
  - If clr_i coincides with an increment event, the result is 0 for err_o/counters; clear wins.
  - clr_i does not affect the FSM.
- Response back-pressure: response-side stalls never drop flits, for unbounded rsp_ready_i=0.

Decomposition:
- Add to picobello_pkg:
  - localparam logic [1:0] RespDecErr = 2'b11.
  - typedef enum edge_rsp_state_e {IDLE, W_DRAIN, R_RESP, B_RESP}.
- Coordinate widths are derived from NumXMesh/NumYMesh.
- The instantiating mesh generate loop enables the block where is_tie_off(x,y,dir) holds and passes TileX/TileY.
- The FSM, counters and response register live in a single module.
- No sub-module; the saturating counter is two instances of a small inline always block, not a separate module.

Test Plan:
- Read header src=(2,1), id=5, len=3, rsp_ready_i=1 -> 4 consecutive R flits starting next cycle, dst=(2,1), id=5, resp=2'b11, last only on 4th; err_cnt_o=1, err_o=1.
- Write header src=(0,1), id=9, then 3 data flits with last on 3rd; a second header presented mid-burst -> second header stalls (req_ready_o=0); one B flit id=9, dst=(0,1), last=1 after last data; then second header accepted.
- Read len=0 with rsp_ready_i=0 for 10 cycles -> rsp_valid_o held, fields stable, single beat delivered on ready, then FSM back in IDLE.
- Two data flits with no preceding header in IDLE -> both accepted, stray_cnt_o=2, no response generated.
- Reset asserted during R_RESP beat 2 of 8 -> next cycle rsp_valid_o=0, counters 0, req_ready_o=1; new read len=1 returns exactly 2 beats.
- Force err_cnt_o to max via CntW=2 build with 5 headers -> err_cnt_o stays at 3; clr_i asserted together with a header handshake -> err_cnt_o=0, err_o=0.

Source files
------------

// File: rtl/picobello_mesh_edge_responder_pkg.sv
// Shared definitions for the mesh edge responder: response code, FSM state
// encoding, mesh geometry and the tie-off predicate used by the mesh generate.
package picobello_mesh_edge_responder_pkg;

    localparam int unsigned NumXMesh = 4;
    localparam int unsigned NumYMesh = 4;

    // Coordinate width that holds NumXMesh-1 and NumYMesh-1.
    localparam int unsigned MeshCoordW =
        ($clog2(NumXMesh) > $clog2(NumYMesh)) ? $clog2(NumXMesh) : $clog2(NumYMesh);

    // Every terminated transaction is answered with DECERR.
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_DRAIN = 2'd1,
        R_RESP  = 2'd2,
        B_RESP  = 2'd3
    } edge_rsp_state_e;

    typedef enum logic [1:0] {
        DIR_NORTH = 2'd0,
        DIR_EAST  = 2'd1,
        DIR_SOUTH = 2'd2,
        DIR_WEST  = 2'd3
    } mesh_dir_e;

    // True when the port of tile (x,y) facing dir leaves the mesh.
    function automatic bit is_tie_off(input int unsigned x, input int unsigned y,
                                      input mesh_dir_e dir);
        case (dir)
            DIR_WEST:  return x == 0;
            DIR_EAST:  return x == NumXMesh - 1;
            DIR_SOUTH: return y == 0;
            default:   return y == NumYMesh - 1;
        endcase
    endfunction

endpackage

// File: rtl/picobello_mesh_edge_responder.sv
// Terminates a tied-off mesh port: consumes misrouted requests and answers
// each one with a DECERR response routed back to the originating tile.
module picobello_mesh_edge_responder
    import picobello_mesh_edge_responder_pkg::*;
#(
    parameter int unsigned TileX  = 0,
    parameter int unsigned TileY  = 0,
    parameter int unsigned CoordW = 2,
    parameter int unsigned IdW    = 4,
    parameter int unsigned LenW   = 8,
    parameter int unsigned CntW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_hdr_i,
    input  logic              req_write_i,
    input  logic [CoordW-1:0] req_src_x_i,
    input  logic [CoordW-1:0] req_src_y_i,
    input  logic [IdW-1:0]    req_id_i,
    input  logic [LenW-1:0]   req_len_i,
    input  logic              req_last_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [CoordW-1:0] rsp_dst_x_o,
    output logic [CoordW-1:0] rsp_dst_y_o,
    output logic [CoordW-1:0] rsp_src_x_o,
    output logic [CoordW-1:0] rsp_src_y_o,
    output logic [IdW-1:0]    rsp_id_o,
    output logic              rsp_write_o,
    output logic              rsp_last_o,
    output logic [1:0]        rsp_resp_o,
    input  logic              clr_i,
    output logic              err_o,
    output logic [CntW-1:0]   err_cnt_o,
    output logic [CntW-1:0]   stray_cnt_o
);

    edge_rsp_state_e   state_q, state_d;
    logic [LenW-1:0]   cnt_q, cnt_d;
    logic [CoordW-1:0] dst_x_q, dst_x_d;
    logic [CoordW-1:0] dst_y_q, dst_y_d;
    logic [IdW-1:0]    id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_last_q, rsp_last_d;
    logic              err_q, err_d;

    logic              req_hs;
    logic              rsp_hs;
    logic              hdr_hs;
    logic [1:0]        stat_inc;
    logic [CntW-1:0]   stat_cnt_q [2];

    // Request acceptance: always in IDLE, data-only while draining, never
    // while a response is pending (that is the single-outstanding stall).
    always_comb begin
        req_ready_o = 1'b0;
        case (state_q)
            IDLE:    req_ready_o = 1'b1;
            W_DRAIN: req_ready_o = !req_hdr_i;
            default: req_ready_o = 1'b0;
        endcase
    end

    assign req_hs = req_valid_i && req_ready_o;
    assign rsp_hs = rsp_valid_q && rsp_ready_i;
    assign hdr_hs = req_hs && req_hdr_i;

    // Next-state and next response register contents; response fields only
    // change when a new response is loaded, so they hold while stalled.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_last_d  = rsp_last_q;
        case (state_q)
            IDLE: begin
                if (hdr_hs) begin
                    dst_x_d = req_src_x_i;
                    dst_y_d = req_src_y_i;
                    id_d    = req_id_i;
                    cnt_d   = req_len_i;
                    if (req_write_i) begin
                        state_d = W_DRAIN;
                    end else begin
                        state_d     = R_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_write_d = 1'b0;
                        rsp_last_d  = (req_len_i == '0);
                    end
                end
            end
            W_DRAIN: begin
                // Beat count is deliberately ignored; only last ends the burst.
                if (req_hs && req_last_i) begin
                    state_d     = B_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_last_d  = 1'b1;
                end
            end
            R_RESP: begin
                if (rsp_hs) begin
                    if (cnt_q == '0) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q - LenW'(1);
                        rsp_last_d = (cnt_q == LenW'(1));
                    end
                end
            end
            B_RESP: begin
                if (rsp_hs) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and response register; reset abandons any partial burst.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Sticky error flag: set by any header, clear has priority.
    always_comb begin
        err_d = err_q;
        if (clr_i) begin
            err_d = 1'b0;
        end else if (hdr_hs) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Counter 0 counts terminated headers, counter 1 counts stray data flits
    // arriving while no transaction is open.
    assign stat_inc[0] = hdr_hs;
    assign stat_inc[1] = req_hs && !req_hdr_i && (state_q == IDLE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat_cnt
        // Saturating status counter; clear wins over a coincident increment.
        always_ff @(posedge clk_i) begin
            if (!rst_ni || clr_i) begin
                stat_cnt_q[gi] <= '0;
            end else if (stat_inc[gi] && (stat_cnt_q[gi] != {CntW{1'b1}})) begin
                stat_cnt_q[gi] <= stat_cnt_q[gi] + CntW'(1);
            end
        end
    end

    assign err_o       = err_q;
    assign err_cnt_o   = stat_cnt_q[0];
    assign stray_cnt_o = stat_cnt_q[1];

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dst_x_o = dst_x_q;
    assign rsp_dst_y_o = dst_y_q;
    assign rsp_src_x_o = CoordW'(TileX);
    assign rsp_src_y_o = CoordW'(TileY);
    assign rsp_id_o    = id_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_resp_o  = RespDecErr;

endmodule
